// File: rtl/seq_mult_pkg.sv
// Shared types for the iterative shift-and-add multiplier.
package seq_mult_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/mult_sign_cond.sv
// Conditional absolute value: negates the operand when signed mode is on and its MSB is set.
module mult_sign_cond #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] val_i,
   input  logic             en_i,
   output logic [WIDTH-1:0] mag_o,
   output logic             sign_o
);

   // -(-2^(WIDTH-1)) wraps back to 2^(WIDTH-1), which is the correct unsigned magnitude
   assign sign_o = en_i & val_i[WIDTH-1];
   assign mag_o  = sign_o ? -val_i : val_i;

endmodule

// File: rtl/seq_mult.sv
// Radix-2 shift-and-add multiplier with valid/ready on both sides.
// Optional SEQ_MULT_EARLY_TERM_EN: finish CALC once the remaining multiplier bits are all zero.
//
// state | meaning
// IDLE  | in_ready=1, waiting for operands
// CALC  | one add/shift step per cycle on magnitudes
// DONE  | product valid, held until out_ready
module seq_mult
   import seq_mult_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   input  logic                 is_signed,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   product,
   output logic                 busy
);

   localparam int PW    = 2 * WIDTH;
   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   state_t           state_q, state_d;
   logic [PW-1:0]    mcand_q, mcand_d;
   logic [PW-1:0]    acc_q, acc_d, acc_next;
   logic [PW-1:0]    product_q, product_d;
   logic [WIDTH-1:0] mplier_q, mplier_d, mplier_next;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             neg_q, neg_d;
   logic [WIDTH-1:0] mag_a, mag_b;
   logic             sign_a, sign_b;
   logic             accept, last_step;

   mult_sign_cond #(.WIDTH(WIDTH)) u_abs_a (
      .val_i  (a),
      .en_i   (is_signed),
      .mag_o  (mag_a),
      .sign_o (sign_a)
   );

   mult_sign_cond #(.WIDTH(WIDTH)) u_abs_b (
      .val_i  (b),
      .en_i   (is_signed),
      .mag_o  (mag_b),
      .sign_o (sign_b)
   );

   assign accept      = in_valid & in_ready;
   assign acc_next    = acc_q + (mplier_q[0] ? mcand_q : '0);
   assign mplier_next = mplier_q >> 1;

`ifdef SEQ_MULT_EARLY_TERM_EN
   assign last_step = (cnt_q == LAST_CNT) || (mplier_next == '0);
`else
   assign last_step = (cnt_q == LAST_CNT);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept)    state_d = CALC;
         CALC:    if (last_step) state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default:                state_d = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state_q == IDLE);
      out_valid = (state_q == DONE);
      busy      = (state_q != IDLE);
   end

   always_comb begin
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      neg_d     = neg_q;
      product_d = product_q;
      if (accept) begin
         mcand_d  = {{WIDTH{1'b0}}, mag_a};
         mplier_d = mag_b;
         acc_d    = '0;
         cnt_d    = '0;
         neg_d    = sign_a ^ sign_b;
      end else if (state_q == CALC) begin
         acc_d    = acc_next;
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_next;
         cnt_d    = cnt_q + CNT_W'(1);
         // product only moves here, so it stays stable through DONE and IDLE
         if (last_step) product_d = neg_q ? -acc_next : acc_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand_q   <= '0;
         mplier_q  <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         neg_q     <= 1'b0;
         product_q <= '0;
      end else begin
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         neg_q     <= neg_d;
         product_q <= product_d;
      end
   end

   assign product = product_q;

endmodule
